// File: rtl/sram_pkg.sv
// Shared electrical levels and FSM encoding for the SRAM array controller.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WL    = 3'd2,
        HOLD  = 3'd3,
        RD_WL = 3'd4,
        RESP  = 3'd5
    } state_t;

    function automatic logic sense(input real v);
        return v >= VTH;
    endfunction

endpackage

// File: rtl/sram_sense.sv
// Bitline-pair comparator bank: recovers the word and flags pairs that
// do not resolve to complementary levels.
module sram_sense
    import sram_pkg::*;
#(
    parameter int COLS = 8
) (
    input  real              r_bl_rd  [COLS],
    input  real              r_blb_rd [COLS],
    output logic [COLS-1:0]  data,
    output logic             fault
);

    always_comb begin
        data  = '0;
        fault = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            data[i] = sense(r_bl_rd[i]);
            if (sense(r_bl_rd[i]) == sense(r_blb_rd[i]))
                fault = 1'b1;
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Single-word read/write controller driving a mixed-signal SRAM array.
// Define SRAM_CTRL_WRITE_VERIFY_EN to read back and compare every write.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 8,
    parameter  int WL_CYCLES = 2,
    localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output real             r_row_wr [ROWS],
    output real             r_row_rd [ROWS],
    output real             r_bl_wr  [COLS],
    output real             r_blb_wr [COLS],
    input  real             r_bl_rd  [COLS],
    input  real             r_blb_rd [COLS]
);

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam int CW = $clog2(WL_CYCLES + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] wdata_q;

    logic            accept;
    logic            wl_done;
    logic            nxt_we;
    logic [AW-1:0]   nxt_addr;
    logic [COLS-1:0] nxt_wdata;
    logic            nxt_ok;
    logic            drive_bl;
    logic [COLS-1:0] s_data;
    logic            s_fault;

    sram_sense #(.COLS(COLS)) u_sense (
        .r_bl_rd  (r_bl_rd),
        .r_blb_rd (r_blb_rd),
        .data     (s_data),
        .fault    (s_fault)
    );

    assign accept    = req_valid && req_ready;
    assign wl_done   = (cnt == CW'(WL_CYCLES - 1));
    // Outputs are registered from next state, so use the request being latched.
    assign nxt_we    = accept ? req_we    : we_q;
    assign nxt_addr  = accept ? req_addr  : addr_q;
    assign nxt_wdata = accept ? req_wdata : wdata_q;
    assign nxt_ok    = int'(nxt_addr) < ROWS;
    assign drive_bl  = nxt_ok && nxt_we &&
                       (state_nxt == SETUP || state_nxt == WL ||
                        state_nxt == HOLD);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = we_q ? WL : RD_WL;
            WL:      if (wl_done) state_nxt = HOLD;
            HOLD:    state_nxt = (VERIFY && we_q) ? RD_WL : RESP;
            RD_WL:   if (wl_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt == state && (state == WL || state == RD_WL))
                         ? cnt + CW'(1) : '0;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_nxt == RESP) begin
                if (state == RD_WL) begin
                    rsp_rdata <= nxt_ok ? s_data : '0;
                    rsp_err   <= !nxt_ok || s_fault ||
                                 (we_q && s_data != wdata_q);
                end else begin
                    rsp_rdata <= '0;
                    rsp_err   <= !nxt_ok;
                end
            end
        end
    end

    // Analog drive; reset clears it asynchronously, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                r_row_wr[r] <= VSS;
                r_row_rd[r] <= VSS;
            end
            for (int c = 0; c < COLS; c++) begin
                r_bl_wr[c]  <= VSS;
                r_blb_wr[c] <= VSS;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                r_row_wr[r] <= VSS;
                r_row_rd[r] <= VSS;
            end
            for (int c = 0; c < COLS; c++) begin
                r_bl_wr[c]  <= (drive_bl &&  nxt_wdata[c]) ? VDD : VSS;
                r_blb_wr[c] <= (drive_bl && !nxt_wdata[c]) ? VDD : VSS;
            end
            if (nxt_ok && state_nxt == WL)
                r_row_wr[nxt_addr] <= VDD;
            if (nxt_ok && state_nxt == RD_WL)
                r_row_rd[nxt_addr] <= VDD;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl against a behavioural 4x8 bitcell array.
// Scoreboard of expected responses is matched against observed rsp_valid pulses.
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int WLC  = 2;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int LAT_RD = WLC + 1;
    localparam int LAT_WR = VER ? 2 * WLC + 2 : WLC + 2;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        bit         chk;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [1:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    real        r_row_wr [ROWS];
    real        r_row_rd [ROWS];
    real        r_bl_wr  [COLS];
    real        r_blb_wr [COLS];
    real        r_bl_rd  [COLS];
    real        r_blb_rd [COLS];

    logic [7:0] mem [ROWS];
    logic [7:0] ovr_bl = '0;
    logic [7:0] ovr_blb = '0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int bad_wl = 0;
    int cur_row = -1;
    int mon_n;
    int mon_hr;
    exp_t exp_q[$];
    rsp_t rsp_q[$];

    sram_ctrl #(.ROWS(ROWS), .COLS(COLS), .WL_CYCLES(WLC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .r_row_wr  (r_row_wr),
        .r_row_rd  (r_row_rd),
        .r_bl_wr   (r_bl_wr),
        .r_blb_wr  (r_blb_wr),
        .r_bl_rd   (r_bl_rd),
        .r_blb_rd  (r_blb_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bitcell array: write wordline captures the write bitlines.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            if (r_row_wr[r] >= VTH)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= (r_bl_wr[c] >= VTH);
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            r_bl_rd[c]  = VSS;
            r_blb_rd[c] = VSS;
        end
        for (int r = 0; r < ROWS; r++)
            if (r_row_rd[r] >= VTH)
                for (int c = 0; c < COLS; c++) begin
                    r_bl_rd[c]  = mem[r][c] ? VDD : VSS;
                    r_blb_rd[c] = mem[r][c] ? VSS : VDD;
                end
        for (int c = 0; c < COLS; c++) begin
            if (ovr_bl[c])  r_bl_rd[c]  = VDD;
            if (ovr_blb[c]) r_blb_rd[c] = VDD;
        end
    end

    always @(negedge clk) begin
        mon_n  = 0;
        mon_hr = -1;
        for (int r = 0; r < ROWS; r++) begin
            if (r_row_wr[r] >= VTH) begin mon_n++; mon_hr = r; end
            if (r_row_rd[r] >= VTH) begin mon_n++; mon_hr = r; end
        end
        if (mon_n > 1 || (mon_n == 1 && cur_row >= 0 && mon_hr != cur_row))
            bad_wl++;
        if (rsp_valid === 1'b1)
            rsp_q.push_back('{rsp_rdata, rsp_err, cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic we, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] er,
                         input logic ee, input bit chk, output bit ok);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) return;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        exp_q.push_back('{er, ee, chk, cyc});
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output bit ok, output rsp_t a, output exp_t e);
        int n = 0;
        while (rsp_q.size() == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (rsp_q.size() != 0);
        e  = (exp_q.size() != 0) ? exp_q.pop_front() : '{8'h00, 1'b0, 1'b0, 0};
        a  = ok ? rsp_q.pop_front() : '{8'h00, 1'b0, 0};
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < ROWS; r++)
            if (r_row_wr[r] != VSS || r_row_rd[r] != VSS) bad++;
        for (int c = 0; c < COLS; c++)
            if (r_bl_wr[c] != VSS || r_blb_wr[c] != VSS) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL reset_reals: %0d nonzero, want 0", bad); end
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        tests++;
        if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL reset_rsp: rdata %h err %b want 00 0", rsp_rdata, rsp_err);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
        @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        bit ok;
        rsp_t a;
        exp_t e;
        real exp_row;
        real exp_bl;
        cur_row = 2;
        issue(1'b1, 2'd2, 8'hA5, VER ? 8'hA5 : 8'h00, 1'b0, 1'b1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL wr_accept: ready never seen"); end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            exp_row = (k == 1 || k == 2) ? VDD : VSS;
            exp_bl  = (k <= 3) ? VDD : VSS;
            tests++;
            if (r_row_wr[2] != exp_row) begin
                fails++; $display("FAIL wr_wl k=%0d: got %0.2f want %0.2f", k, r_row_wr[2], exp_row);
            end
            tests++;
            if (r_bl_wr[0] != exp_bl || r_blb_wr[1] != exp_bl || r_bl_wr[1] != VSS) begin
                fails++; $display("FAIL wr_bl k=%0d: bl0 %0.2f blb1 %0.2f bl1 %0.2f want %0.2f", k, r_bl_wr[0], r_blb_wr[1], r_bl_wr[1], exp_bl);
            end
            if (k == 4 && !VER) begin
                tests++;
                if (rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rsp_edge: rsp_valid %b want 1", rsp_valid); end
            end
        end
        for (int t = 0; t < 2; t++) begin
            if (t == 1) issue(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 1'b1, ok);
            get_rsp(ok, a, e);
            tests++;
            if (!ok) begin fails++; $display("FAIL wr_rd_rsp%0d: no response", t); end
            else begin
                tests++;
                if (a.rdata !== e.rdata || a.err !== e.err) begin
                    fails++; $display("FAIL wr_rd_data%0d: got %h/%b want %h/%b", t, a.rdata, a.err, e.rdata, e.err);
                end
                tests++;
                if (a.cyc - e.acc !== (t == 0 ? LAT_WR : LAT_RD)) begin
                    fails++; $display("FAIL wr_rd_lat%0d: got %0d want %0d", t, a.cyc - e.acc, t == 0 ? LAT_WR : LAT_RD);
                end
            end
        end
        cur_row = -1;
    endtask

    task automatic test_row_isolation();
        bit         tw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ta [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
        logic [7:0] td [5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] tr [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hA5};
        bit ok;
        rsp_t a;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            cur_row = int'(ta[i]);
            issue(tw[i], ta[i], td[i], tw[i] ? (VER ? td[i] : 8'h00) : tr[i], 1'b0, 1'b1, ok);
            get_rsp(ok, a, e);
            tests++;
            if (!ok) begin fails++; $display("FAIL iso_rsp%0d: no response", i); end
            else begin
                tests++;
                if (a.rdata !== e.rdata || a.err !== e.err) begin
                    fails++; $display("FAIL iso_data%0d: got %h/%b want %h/%b", i, a.rdata, a.err, e.rdata, e.err);
                end
            end
        end
        cur_row = -1;
        tests++;
        if (bad_wl !== 0) begin fails++; $display("FAIL iso_wordline: %0d bad cycles, want 0", bad_wl); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rsp_t a;
        exp_t e;
        int acc0;
        issue(1'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1, ok);
        issue(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1, ok);
        for (int t = 0; t < 2; t++) begin
            get_rsp(ok, a, e);
            tests++;
            if (!ok) begin fails++; $display("FAIL b2b_rsp%0d: no response", t); end
            else begin
                tests++;
                if (a.rdata !== e.rdata || a.err !== e.err || a.cyc - e.acc !== LAT_RD) begin
                    fails++; $display("FAIL b2b_data%0d: got %h/%b lat %0d want %h/%b lat %0d", t, a.rdata, a.err, a.cyc - e.acc, e.rdata, e.err, LAT_RD);
                end
                if (t == 0) acc0 = e.acc;
                else begin
                    tests++;
                    if (e.acc - acc0 !== LAT_RD + 2) begin
                        fails++; $display("FAIL b2b_gap: got %0d want %0d", e.acc - acc0, LAT_RD + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_sense_fault();
        bit ok;
        rsp_t a;
        exp_t e;
        ovr_bl  = 8'h08;
        ovr_blb = 8'h08;
        issue(1'b0, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, ok);
        get_rsp(ok, a, e);
        ovr_bl  = 8'h00;
        ovr_blb = 8'h00;
        tests++;
        if (!ok || a.err !== e.err) begin fails++; $display("FAIL fault_err: got %b want %b", a.err, e.err); end
        issue(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 1'b1, ok);
        get_rsp(ok, a, e);
        tests++;
        if (!ok || a.err !== e.err || a.rdata !== e.rdata) begin
            fails++; $display("FAIL fault_clear: got %h/%b want %h/%b", a.rdata, a.err, e.rdata, e.err);
        end
    endtask

    task automatic test_verify();
        bit ok;
        rsp_t a;
        exp_t e;
        issue(1'b1, 2'd3, 8'h3C, VER ? 8'h3C : 8'h00, 1'b0, 1'b1, ok);
        get_rsp(ok, a, e);
        tests++;
        if (!ok || a.rdata !== e.rdata || a.err !== e.err || a.cyc - e.acc !== LAT_WR) begin
            fails++; $display("FAIL verify_ok: got %h/%b lat %0d want %h/%b lat %0d", a.rdata, a.err, a.cyc - e.acc, e.rdata, e.err, LAT_WR);
        end
        ovr_bl = 8'h01;
        issue(1'b1, 2'd3, 8'h3C, VER ? 8'h3D : 8'h00, VER, 1'b1, ok);
        get_rsp(ok, a, e);
        ovr_bl = 8'h00;
        tests++;
        if (!ok || a.rdata !== e.rdata || a.err !== e.err) begin
            fails++; $display("FAIL verify_bad: got %h/%b want %h/%b", a.rdata, a.err, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int bad = 0;
        issue(1'b1, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b1, ok);
        @(posedge clk);
        #1;
        tests++;
        if (r_row_wr[1] != VDD) begin fails++; $display("FAIL midrst_pre: wl %0.2f want 1.50", r_row_wr[1]); end
        #1 rst_n = 1'b0;
        #1;
        for (int r = 0; r < ROWS; r++)
            if (r_row_wr[r] != VSS || r_row_rd[r] != VSS) bad++;
        for (int c = 0; c < COLS; c++)
            if (r_bl_wr[c] != VSS || r_blb_wr[c] != VSS) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL midrst_reals: %0d nonzero, want 0", bad); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (rsp_q.size() !== 0) begin fails++; $display("FAIL midrst_rsp: %0d responses want 0", rsp_q.size()); end
        tests++;
        if (req_ready !== 1'b1 || rsp_rdata !== 8'h00) begin
            fails++; $display("FAIL midrst_idle: ready %b rdata %h want 1 00", req_ready, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_row_isolation();
        test_back_to_back();
        test_sense_fault();
        test_verify();
        test_reset_mid_write();
        tests++;
        if (bad_wl !== 0) begin fails++; $display("FAIL wordline_exclusive: %0d bad cycles, want 0", bad_wl); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
